// File: rtl/aes_axis_ingress.sv
// AXI4-Stream ingress for the AES controller: 2-entry skid buffer, command/payload
// framing, and zero padding of misaligned or empty payloads to whole 128-bit blocks.
module aes_axis_ingress #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BLOCK_WORDS    = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [BUS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      controller_in_busy,
    output logic                      in_bus_data_wren,
    output logic                      in_bus_tlast,
    output logic [BUS_DATA_WIDTH-1:0] in_bus_data,
    output logic                      err_len,
    output logic [CNT_WIDTH-1:0]      pkt_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt
);
    localparam int PH_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int PAD_W = $clog2(BLOCK_WORDS + 1);
    localparam int ENT_W = BUS_DATA_WIDTH + 1;

    localparam logic [PH_W-1:0]      PH_ZERO   = {PH_W{1'b0}};
    localparam logic [PH_W-1:0]      PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]      PH_LAST   = PH_W'(BLOCK_WORDS - 1);
    localparam logic [PAD_W-1:0]     PAD_ONE   = PAD_W'(1);
    localparam logic [PAD_W-1:0]     PAD_BLOCK = PAD_W'(BLOCK_WORDS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_PAD  = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [ENT_W-1:0]          buf0_r;
    logic [ENT_W-1:0]          buf1_r;
    logic [1:0]                occ_r;
    logic [1:0]                occ_nxt_s;
    logic                      ready_r;
    logic [PH_W-1:0]           phase_r;
    logic                      started_r;
    logic [PAD_W-1:0]          pad_cnt_r;

    logic                      push_s;
    logic                      pop_s;
    logic                      emit_s;
    logic                      tlast_s;
    logic                      err_s;
    logic                      pkt_done_s;
    logic [BUS_DATA_WIDTH-1:0] data_s;
    logic [ENT_W-1:0]          in_ent_s;
    logic                      head_last_s;
    logic                      aligned_s;

    assign s_axis_tready = ready_r;
    assign push_s        = s_axis_tvalid && ready_r;
    assign in_ent_s      = {s_axis_tlast, s_axis_tdata};
    assign head_last_s   = buf0_r[ENT_W-1];
    // phase_r is the payload count mod BLOCK_WORDS; started_r marks a non-empty payload.
    assign aligned_s     = started_r && (phase_r == PH_ZERO);
    assign occ_nxt_s     = occ_r + {1'b0, push_s} - {1'b0, pop_s};

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_PASS;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_PASS: begin
                if (pop_s && head_last_s && !aligned_s) begin
                    state_nxt_s = ST_PAD;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_PAD: begin
                if (emit_s && (pad_cnt_r == PAD_ONE)) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_PAD;
                end
            end
            default: state_nxt_s = ST_PASS;
        endcase
    end

    // Output decode: what goes to the controller this cycle
    always_comb begin
        pop_s      = 1'b0;
        emit_s     = 1'b0;
        tlast_s    = 1'b0;
        err_s      = 1'b0;
        pkt_done_s = 1'b0;
        data_s     = {BUS_DATA_WIDTH{1'b0}};
        case (state_r)
            ST_PASS: begin
                if ((occ_r != 2'd0) && !controller_in_busy) begin
                    pop_s  = 1'b1;
                    emit_s = 1'b1;
                    data_s = buf0_r[BUS_DATA_WIDTH-1:0];
                    if (head_last_s && aligned_s) begin
                        tlast_s    = 1'b1;
                        pkt_done_s = 1'b1;
                    end else if (head_last_s) begin
                        err_s = 1'b1;
                    end else begin
                        tlast_s = 1'b0;
                    end
                end else begin
                    pop_s = 1'b0;
                end
            end
            ST_PAD: begin
                if (!controller_in_busy) begin
                    emit_s = 1'b1;
                    if (pad_cnt_r == PAD_ONE) begin
                        tlast_s    = 1'b1;
                        pkt_done_s = 1'b1;
                    end else begin
                        tlast_s = 1'b0;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: begin
                emit_s = 1'b0;
            end
        endcase
    end

    // Skid buffer: entry 0 is always the head; ready reflects next-cycle occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf0_r  <= {ENT_W{1'b0}};
            buf1_r  <= {ENT_W{1'b0}};
            occ_r   <= 2'd0;
            ready_r <= 1'b0;
        end else begin
            occ_r   <= occ_nxt_s;
            ready_r <= (occ_nxt_s < 2'd2);
            if (push_s && pop_s) begin
                if (occ_r == 2'd2) begin
                    buf0_r <= buf1_r;
                    buf1_r <= in_ent_s;
                end else begin
                    buf0_r <= in_ent_s;
                end
            end else if (push_s) begin
                if (occ_r == 2'd0) begin
                    buf0_r <= in_ent_s;
                end else begin
                    buf1_r <= in_ent_s;
                end
            end else if (pop_s) begin
                buf0_r <= buf1_r;
            end
        end
    end

    // Packet framing: payload phase and the pad countdown
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_r   <= PH_ZERO;
            started_r <= 1'b0;
            pad_cnt_r <= {PAD_W{1'b0}};
        end else if (pop_s) begin
            if (head_last_s) begin
                phase_r   <= PH_ZERO;
                started_r <= 1'b0;
                // Covers the empty payload too: phase 0 yields a full block of padding.
                pad_cnt_r <= PAD_BLOCK - PAD_W'(phase_r);
            end else begin
                started_r <= 1'b1;
                phase_r   <= (phase_r == PH_LAST) ? PH_ZERO : (phase_r + PH_ONE);
            end
        end else if ((state_r == ST_PAD) && emit_s) begin
            pad_cnt_r <= pad_cnt_r - PAD_ONE;
        end
    end

    // Registered controller interface and saturating statistics
    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_bus_data_wren <= 1'b0;
            in_bus_tlast     <= 1'b0;
            in_bus_data      <= {BUS_DATA_WIDTH{1'b0}};
            err_len          <= 1'b0;
            pkt_cnt          <= {CNT_WIDTH{1'b0}};
            err_cnt          <= {CNT_WIDTH{1'b0}};
        end else begin
            in_bus_data_wren <= emit_s;
            in_bus_tlast     <= tlast_s;
            in_bus_data      <= data_s;
            err_len          <= err_s;
            if (pkt_done_s && (pkt_cnt != CNT_MAX)) begin
                pkt_cnt <= pkt_cnt + CNT_ONE;
            end
            if (err_s && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_aes_axis_ingress.sv
// Bench for aes_axis_ingress: packet-level reference model (expected word stream with
// padding), table of packet shapes, hand sequences for stall/back-to-back/reset, random traffic.
module tb_aes_axis_ingress;
    localparam int W  = 32;
    localparam int B  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic          controller_in_busy;
    logic          in_bus_data_wren;
    logic          in_bus_tlast;
    logic [W-1:0]  in_bus_data;
    logic          err_len;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] err_cnt;

    aes_axis_ingress #(.BUS_DATA_WIDTH(W), .BLOCK_WORDS(B), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .controller_in_busy (controller_in_busy),
        .in_bus_data_wren   (in_bus_data_wren),
        .in_bus_tlast       (in_bus_tlast),
        .in_bus_data        (in_bus_data),
        .err_len            (err_len),
        .pkt_cnt            (pkt_cnt),
        .err_cnt            (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; logic last; } in_word_t;
    typedef struct { logic [W-1:0] data; logic tlast; logic pad; logic err; } out_word_t;
    typedef struct { int payload; int exp_pads; int exp_err; bit rand_timing; } vec_t;

    in_word_t  tx_q[$];
    out_word_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int accepted, real_out, seen_pkt, seen_err, added_err;
    int obs_words, obs_tlast, obs_err, obs_pad;
    bit gap_en, busy_rand, busy_force;
    bit busy_prev, tvalid_prev, tready_prev, resetn_prev, hs;

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a packet is cmd + n payload words; pad to the next block if n is 0 or not a multiple of B.
    task automatic add_packet(input int n, input logic [W-1:0] cmd);
        in_word_t  iw;
        out_word_t ow;
        int        pads;
        pads = (n == 0) ? B : (((n % B) == 0) ? 0 : B - (n % B));
        for (int i = 0; i <= n; i++) begin
            iw.data = (i == 0) ? cmd : $urandom;
            iw.last = (i == n);
            tx_q.push_back(iw);
            ow.data  = iw.data;
            ow.pad   = 1'b0;
            ow.tlast = iw.last && (pads == 0);
            ow.err   = iw.last && (pads != 0);
            exp_q.push_back(ow);
        end
        for (int p = 0; p < pads; p++) begin
            ow.data  = '0;
            ow.pad   = 1'b1;
            ow.tlast = (p == pads - 1);
            ow.err   = 1'b0;
            exp_q.push_back(ow);
        end
        if (pads != 0) added_err++;
    endtask

    task automatic step();
        out_word_t ow;
        busy_prev   = controller_in_busy;
        tvalid_prev = s_axis_tvalid;
        tready_prev = s_axis_tready;
        resetn_prev = resetn;
        @(posedge clk);
        #1;
        hs = 1'b0;
        if (!resetn_prev) begin
            expect_eq("rst_wren", in_bus_data_wren, 0);
            expect_eq("rst_tlast", in_bus_tlast, 0);
            expect_eq("rst_data", in_bus_data, 0);
            expect_eq("rst_err_len", err_len, 0);
            expect_eq("rst_tready", s_axis_tready, 0);
            expect_eq("rst_pkt_cnt", pkt_cnt, 0);
            expect_eq("rst_err_cnt", err_cnt, 0);
            accepted = 0; real_out = 0; seen_pkt = 0; seen_err = 0;
        end else begin
            if (tvalid_prev && tready_prev) begin
                hs = 1'b1;
                void'(tx_q.pop_front());
                accepted++;
            end
            if (in_bus_data_wren) begin
                checks++;
                if (busy_prev) begin
                    errors++;
                    $display("FAIL wren_while_busy: got wren=1 with busy=1, expected wren=0");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got data=%h tlast=%b, expected no word", in_bus_data, in_bus_tlast);
                end else begin
                    ow = exp_q.pop_front();
                    if (in_bus_data !== ow.data || in_bus_tlast !== ow.tlast || err_len !== ow.err) begin
                        errors++;
                        $display("FAIL word: got data=%h tlast=%b err_len=%b, expected data=%h tlast=%b err_len=%b",
                                 in_bus_data, in_bus_tlast, err_len, ow.data, ow.tlast, ow.err);
                    end
                    if (!ow.pad) real_out++;
                    if (ow.tlast) seen_pkt++;
                    if (ow.err) seen_err++;
                    obs_pad += ow.pad;
                end
                obs_words++;
                obs_tlast += in_bus_tlast;
                obs_err   += err_len;
            end else begin
                expect_eq("err_len_idle", err_len, 0);
            end
            expect_eq("tready", s_axis_tready, ((accepted - real_out) < 2));
            expect_eq("pkt_cnt", pkt_cnt, seen_pkt);
            expect_eq("err_cnt", err_cnt, seen_err);
        end
        // Drive next inputs; a presented word is held until it is accepted.
        if (s_axis_tvalid && !hs && resetn) begin
            s_axis_tvalid = 1'b1;
        end else if (resetn && tx_q.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_q[0].data;
            s_axis_tlast  = tx_q[0].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tlast  = 1'b0;
        end
        controller_in_busy = busy_force ? 1'b1 : (busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (tx_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d input and %0d output words pending, expected 0",
                     name, tx_q.size(), exp_q.size());
            tx_q.delete();
            exp_q.delete();
            s_axis_tvalid = 1'b0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int   p0, e0, n;
        vecs[0] = '{8, 0, 0, 0};
        vecs[1] = '{5, 3, 1, 0};
        vecs[2] = '{0, 4, 1, 0};
        vecs[3] = '{2, 2, 1, 1};
        vecs[4] = '{4, 0, 0, 1};
        vecs[5] = '{1, 3, 1, 1};
        vecs[6] = '{3, 1, 1, 1};
        vecs[7] = '{7, 1, 1, 1};
        vecs[8] = '{12, 0, 0, 1};

        resetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        controller_in_busy = 1'b0; gap_en = 1'b0; busy_rand = 1'b0; busy_force = 1'b0;
        accepted = 0; real_out = 0; seen_pkt = 0; seen_err = 0; added_err = 0;
        obs_words = 0; obs_tlast = 0; obs_err = 0; obs_pad = 0;
        repeat (3) step();
        resetn = 1'b1;
        repeat (2) step();

        // Table of packet shapes
        for (int i = 0; i < 9; i++) begin
            p0 = pkt_cnt; e0 = err_cnt;
            obs_words = 0; obs_tlast = 0; obs_err = 0;
            gap_en = vecs[i].rand_timing; busy_rand = vecs[i].rand_timing;
            add_packet(vecs[i].payload, (i == 0) ? 32'h0000_0011 : {16'hC0DE, 16'(i)});
            drain(1000, $sformatf("vec%0d", i));
            busy_rand = 1'b0;
            expect_eq($sformatf("vec%0d_words", i), obs_words, vecs[i].payload + 1 + vecs[i].exp_pads);
            expect_eq($sformatf("vec%0d_err_pulses", i), obs_err, vecs[i].exp_err);
            expect_eq($sformatf("vec%0d_tlast", i), obs_tlast, 1);
            expect_eq($sformatf("vec%0d_pkt_delta", i), pkt_cnt - p0, 1);
            expect_eq($sformatf("vec%0d_err_delta", i), err_cnt - e0, vecs[i].exp_err);
        end
        repeat (2) step();

        // Back-pressure: busy for 10 cycles mid-packet with tvalid held high
        gap_en = 1'b0; busy_rand = 1'b0;
        add_packet(8, 32'h0000_0022);
        repeat (3) step();
        busy_force = 1'b1; controller_in_busy = 1'b1;
        repeat (10) step();
        expect_eq("bp_tready", s_axis_tready, 0);
        expect_eq("bp_wren", in_bus_data_wren, 0);
        expect_eq("bp_occupancy", accepted - real_out, 2);
        busy_force = 1'b0; controller_in_busy = 1'b0;
        drain(200, "bp");

        // Back-to-back: misaligned cmd+2 followed directly by aligned cmd+4
        p0 = pkt_cnt; e0 = err_cnt;
        add_packet(2, 32'h0000_0033);
        add_packet(4, 32'h0000_0044);
        drain(200, "b2b");
        expect_eq("b2b_pkt_delta", pkt_cnt - p0, 2);
        expect_eq("b2b_err_delta", err_cnt - e0, 1);

        // Reset while the second pad word would be emitted
        add_packet(1, 32'h0000_0055);
        obs_pad = 0; n = 0;
        while (obs_pad < 1 && n < 100) begin
            step();
            n++;
        end
        expect_eq("rst_pad_seen", obs_pad, 1);
        resetn = 1'b0; s_axis_tvalid = 1'b0; controller_in_busy = 1'b0;
        step();
        tx_q.delete(); exp_q.delete();
        resetn = 1'b1;
        add_packet(4, 32'h0000_0066);
        drain(200, "post_rst");
        expect_eq("post_rst_pkt_cnt", pkt_cnt, 1);
        expect_eq("post_rst_err_cnt", err_cnt, 0);

        // Random traffic with gaps and busy
        p0 = pkt_cnt; e0 = err_cnt; added_err = 0;
        gap_en = 1'b1; busy_rand = 1'b1;
        for (int k = 0; k < 40; k++) add_packet($urandom_range(0, 13), $urandom);
        drain(20000, "rand");
        busy_rand = 1'b0;
        repeat (2) step();
        expect_eq("rand_pkt_cnt", pkt_cnt, p0 + 40);
        expect_eq("rand_err_cnt", err_cnt, e0 + added_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
